// File: rtl/punc_debug_dumper.sv
// punc_debug_dumper
// Streams a debug snapshot of a small processor over a valid/ready port:
// first RF_REGS register-file entries, then the PC, then mem_count memory
// words starting at mem_base. Each word is fetched through a registered
// debug read address, captured at the end of a one-cycle FETCH state and
// held in WAIT until the downstream accepts it.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             dump request (honoured only in IDLE)
//   mem_base          first memory address to dump (sampled with start)
//   mem_count         number of memory words to dump (sampled with start)
//   mem_debug_addr    memory debug read address (registered)
//   rf_debug_addr     register-file debug read address (registered)
//   mem_debug_data    memory read data for mem_debug_addr
//   rf_debug_data     register-file read data for rf_debug_addr
//   pc_debug_data     current PC
//   out_valid/ready   output handshake
//   out_data          dumped word
//   out_tag           0 = RF, 1 = PC, 2 = MEM
//   out_index         register number, 0 for PC, or offset from mem_base
//   busy              high whenever the block is not idle
//   done              one-cycle pulse after the dump completes
module punc_debug_dumper #(
  parameter int RF_REGS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_count,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic [15:0] out_index,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  PH_RF   = 2'd0;
  localparam logic [1:0]  PH_PC   = 2'd1;
  localparam logic [1:0]  PH_MEM  = 2'd2;
  localparam logic [15:0] RF_LAST = 16'(RF_REGS - 1);

  state_t      state_r, state_s;
  logic [1:0]  phase_r, phase_s;
  logic [15:0] idx_r, idx_s;
  logic [15:0] base_r, base_s;
  logic [15:0] count_r, count_s;
  logic        load_addr_s;
  logic [15:0] mem_addr_s;
  logic [15:0] fetch_data_s;

  logic [15:0] mem_addr_r;
  logic [2:0]  rf_addr_r;
  logic        valid_r;
  logic [15:0] data_r;
  logic [1:0]  tag_r;
  logic [15:0] index_r;
  logic        busy_r;
  logic        done_r;

  assign mem_debug_addr = mem_addr_r;
  assign rf_debug_addr  = rf_addr_r;
  assign out_valid      = valid_r;
  assign out_data       = data_r;
  assign out_tag        = tag_r;
  assign out_index      = index_r;
  assign busy           = busy_r;
  assign done           = done_r;

  // Next-state, phase/index sequencing and debug-address load request.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    idx_s       = idx_r;
    base_s      = base_r;
    count_s     = count_r;
    load_addr_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          base_s      = mem_base;
          count_s     = mem_count;
          phase_s     = PH_RF;
          idx_s       = 16'd0;
          load_addr_s = 1'b1;
          state_s     = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: state_s = S_WAIT;
      S_WAIT: begin
        if (out_ready) begin
          case (phase_r)
            PH_RF: begin
              load_addr_s = 1'b1;
              state_s     = S_FETCH;
              if (idx_r < RF_LAST) begin
                idx_s = idx_r + 16'd1;
              end else begin
                phase_s = PH_PC;
              end
            end
            PH_PC: begin
              if (count_r == 16'd0) begin
                state_s = S_DONE;
              end else begin
                phase_s     = PH_MEM;
                idx_s       = 16'd0;
                load_addr_s = 1'b1;
                state_s     = S_FETCH;
              end
            end
            PH_MEM: begin
              // count_r is non-zero whenever the MEM phase is entered
              if (idx_r < count_r - 16'd1) begin
                idx_s       = idx_r + 16'd1;
                load_addr_s = 1'b1;
                state_s     = S_FETCH;
              end else begin
                state_s = S_DONE;
              end
            end
            default: state_s = S_DONE;
          endcase
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Address of the next fetch and source of the captured word.
  always_comb begin
    mem_addr_s   = base_s + idx_s;
    fetch_data_s = rf_debug_data;
    case (phase_r)
      PH_PC:   fetch_data_s = pc_debug_data;
      PH_MEM:  fetch_data_s = mem_debug_data;
      default: fetch_data_s = rf_debug_data;
    endcase
  end

  // Control state: FSM, phase, item counter and latched dump parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      phase_r <= PH_RF;
      idx_r   <= 16'd0;
      base_r  <= 16'd0;
      count_r <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      idx_r   <= idx_s;
      base_r  <= base_s;
      count_r <= count_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_r == S_DONE);
    end
  end

  // Debug read addresses, updated only on entry to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_r <= 16'd0;
      rf_addr_r  <= 3'd0;
    end else if (load_addr_s) begin
      mem_addr_r <= mem_addr_s;
      if (phase_s == PH_RF) begin
        rf_addr_r <= idx_s[2:0];
      end
    end
  end

  // Output word register: captured at the end of FETCH, held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= 16'd0;
      tag_r   <= 2'd0;
      index_r <= 16'd0;
    end else if (state_r == S_FETCH) begin
      valid_r <= 1'b1;
      data_r  <= fetch_data_s;
      tag_r   <= phase_r;
      index_r <= (phase_r == PH_PC) ? 16'd0 : idx_r;
    end else if (state_r == S_WAIT && out_ready) begin
      valid_r <= 1'b0;
    end
  end

endmodule
